// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared definitions for the spi_controller slice: frame geometry,
//            peripheral register addresses, FSM state encoding and the
//            packed command word.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;

  // Peripheral register map
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  typedef struct packed {
    logic                  write;
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_DATA_W-1:0] data;
  } spi_cmd_t;

  // Wire order of a command on the link, MSB first.
  function automatic logic [SPI_FRAME_W-1:0] spi_frame(input spi_cmd_t c);
    return {c.write, c.addr, c.data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_cmd_fifo
// Purpose  : Synchronous command FIFO with full/empty flags. Read data is
//            the head entry, valid whenever empty_o is low (show-ahead).
// Ports    : clk, rst (async, active high)
//            push_i/wdata_i  - write side, ignored when full
//            pop_i/rdata_o   - read side, pop ignored when empty
//            full_o, empty_o - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_controller
// Purpose  : SPI mode-0 initiator for 16-bit {write, addr[6:0], data[7:0]}
//            register-write frames. Commands arrive on a valid/ready
//            handshake; each is shifted MSB-first on registered SCLK/MOSI/
//            CS_n, paced in clk cycles for a synchronised peripheral.
// Ports    : clk, rst (async, active high)
//            req_valid/req_ready, req_write, req_addr, req_data - command in
//            busy  - frame, CS gap (or queued command) in progress
//            done  - one-cycle pulse per completed frame
//            sclk, mosi, cs_n - SPI link (sclk idles low)
// Config   : SPI_CONTROLLER_FIFO_EN - when defined, a FIFO_DEPTH command
//            FIFO buffers requests in front of the FSM.
// Revision : 1.0 - initial release
// ============================================================================
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic [SPI_DATA_W-1:0] req_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n
);

  // The peripheral needs >= 3 cycles per SCLK level after its synchroniser.
  generate
    if (HALF_PERIOD < 4 || CS_GAP < 4 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("spi_controller: illegal HALF_PERIOD, CS_GAP or FIFO_DEPTH");
    end
  endgenerate

  localparam int TMR_MAX = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] HP_LOAD  = TMR_W'(HALF_PERIOD - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(CS_GAP - 1);
  localparam logic [4:0]       LAST_BIT = 5'(SPI_FRAME_W - 1);

  spi_state_e             state_q;
  logic [TMR_W-1:0]       tmr_q;      // cycles left in the current state, minus one
  logic [4:0]             bit_cnt_q;  // completed SCLK high phases
  logic [SPI_FRAME_W-1:0] shift_q;
  logic                   sclk_q;
  logic                   mosi_q;
  logic                   cs_n_q;
  logic                   done_q;

  spi_cmd_t               cmd_in;     // command presented to IDLE
  logic                   cmd_avail;  // IDLE may load cmd_in this cycle

`ifdef SPI_CONTROLLER_FIFO_EN
  logic     fifo_full;
  logic     fifo_empty;
  spi_cmd_t fifo_rdata;
  spi_cmd_t fifo_wdata;

  assign fifo_wdata = '{write: req_write, addr: req_addr, data: req_data};
  assign req_ready  = !fifo_full && !rst;
  // IDLE pops the head the same cycle it loads the shift register.
  assign cmd_avail  = (state_q == ST_IDLE) && !fifo_empty;
  assign cmd_in     = fifo_rdata;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

  spi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(spi_cmd_t))
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid && req_ready),
    .wdata_i (fifo_wdata),
    .pop_i   (cmd_avail),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
`else
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign cmd_avail = req_valid && req_ready;
  assign cmd_in    = '{write: req_write, addr: req_addr, data: req_data};
  assign busy      = (state_q != ST_IDLE);
`endif

  // All link outputs are set on the transition into each state, so they
  // are registered and always consistent with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_avail) begin
            shift_q   <= spi_frame(cmd_in);
            mosi_q    <= cmd_in.write;
            bit_cnt_q <= '0;
            cs_n_q    <= 1'b0;
            sclk_q    <= 1'b0;
            tmr_q     <= HP_LOAD;
            state_q   <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (tmr_q == '0) begin
            sclk_q  <= 1'b1;
            tmr_q   <= HP_LOAD;
            state_q <= ST_HIGH;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_HIGH: begin
          if (tmr_q == '0) begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
            sclk_q    <= 1'b0;
            tmr_q     <= HP_LOAD;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= ST_TRAIL;
            end else begin
              // Next bit goes out on the falling edge, half a period
              // ahead of the rising edge that samples it.
              shift_q <= {shift_q[SPI_FRAME_W-2:0], 1'b0};
              mosi_q  <= shift_q[SPI_FRAME_W-2];
              state_q <= ST_LOW;
            end
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_LOW: begin
          if (tmr_q == '0) begin
            sclk_q  <= 1'b1;
            tmr_q   <= HP_LOAD;
            state_q <= ST_HIGH;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_TRAIL: begin
          if (tmr_q == '0) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            tmr_q   <= GAP_LOAD;
            state_q <= ST_GAP;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_GAP: begin
          if (tmr_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        default: begin
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_controller
// Purpose  : Self-checking bench for spi_controller. A monitor decodes the
//            SPI link like the peripheral would (bits at SCLK rises, frame
//            commit on CS_n rise with exactly 16 bits) and keeps a model of
//            the peripheral register file; expected frames, timing and
//            register contents are derived from the commands issued.
// Config   : SPI_CONTROLLER_FIFO_EN - also runs the FIFO burst scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

  localparam int HP  = 4;
  localparam int CSG = 5;
  localparam int FD  = 4;
`ifdef SPI_CONTROLLER_FIFO_EN
  localparam int LAT  = 2;
  localparam int LAT2 = -1;
`else
  localparam int LAT  = 1;
  localparam int LAT2 = 1;
`endif

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       mosi;
  logic       cs_n;

  spi_controller #(
    .HALF_PERIOD (HP),
    .CS_GAP      (CSG),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .busy      (busy),
    .done      (done),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    int          rises;
    int          low;
    int          fall;
    int          gap;
  } obs_t;

  typedef struct {
    logic [15:0] word;
    int          lat;
    int          gap;
  } exp_t;

  obs_t        obs_q[$];
  exp_t        exp_q[$];
  int          acc_q[$];
  logic [7:0]  preg[5];     // peripheral registers as decoded from the link
  logic [7:0]  ref_reg[5];  // registers implied by the commands issued
  int          frames_sent = 0;
  int          done_cnt    = 0;

  // Link monitor / peripheral model
  int          rises = 0;
  logic [15:0] bits;
  int          fall_cyc, last_rise, csrise_cyc, gap_cur;
  bit          have_rise = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

  initial begin
    obs_t o;
    for (int i = 0; i < 5; i++) preg[i] = 8'h00;
    bits = '0; fall_cyc = 0; last_rise = 0; csrise_cyc = 0; gap_cur = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cs   = 1'b1;
        prev_sclk = 1'b0;
        prev_mosi = 1'b0;
        rises     = 0;
        have_rise = 0;
      end else begin
        if (cs_n) chk_eq("sclk_low_when_cs_high", sclk, 1'b0);
        if (sclk && prev_sclk) chk_eq("mosi_stable_sclk_high", mosi, prev_mosi);
        if (!cs_n && prev_cs) begin
          fall_cyc = cyc;
          rises    = 0;
          bits     = '0;
          gap_cur  = have_rise ? (cyc - csrise_cyc) : -1;
          if (have_rise) chk_eq("cs_gap_min", (cyc - csrise_cyc) >= (CSG + 1), 1'b1);
        end
        if (sclk && !prev_sclk) begin
          rises++;
          bits = {bits[14:0], mosi};
          if (rises == 1) chk_eq("first_rise_delay", cyc - fall_cyc, HP);
          else            chk_eq("sclk_period", cyc - last_rise, 2 * HP);
          last_rise = cyc;
        end
        if (cs_n && !prev_cs) begin
          csrise_cyc = cyc;
          have_rise  = 1;
          o.word  = bits;
          o.rises = rises;
          o.low   = cyc - fall_cyc;
          o.fall  = fall_cyc;
          o.gap   = gap_cur;
          obs_q.push_back(o);
          chk_eq("done_at_cs_rise", done, rises == 16);
          if (rises == 16 && bits[15] && bits[14:8] < 7'd5) preg[bits[10:8]] = bits[7:0];
        end
        if (done) begin
          done_cnt++;
          chk_eq("done_needs_full_frame", (cs_n && !prev_cs && rises == 16), 1'b1);
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_mosi = mosi;
      end
    end
  end

  // Drive one command, starting at a negedge; returns at the negedge after
  // the handshake with req_valid still high.
  task automatic push_cmd(input logic [15:0] w, input int lat, input int gap, input bit keep);
    int   n;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_write = w[15];
    req_addr  = w[14:8];
    req_data  = w[7:0];
    while (!req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("req_ready_handshake", req_ready, 1'b1);
    if (keep) begin
      acc_q.push_back(cyc);
      e.word = w; e.lat = lat; e.gap = gap;
      exp_q.push_back(e);
      frames_sent++;
      if (w[15] && w[14:8] < 7'd5) ref_reg[w[10:8]] = w[7:0];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_frames();
    int n;
    n = 0;
    while ((obs_q.size() < exp_q.size() || busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("frame_count", obs_q.size(), exp_q.size());
  endtask

  task automatic compare_frames();
    exp_t e;
    obs_t o;
    int   a;
    while (exp_q.size() > 0 && obs_q.size() > 0 && acc_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      a = acc_q.pop_front();
      chk_eq("frame_word", o.word, e.word);
      chk_eq("frame_rises", o.rises, 16);
      chk_eq("cs_low_cycles", o.low, 33 * HP);
      if (e.lat >= 0) chk_eq("accept_to_cs_fall", o.fall - a, e.lat);
      if (e.gap >= 0) chk_eq("cs_high_gap", o.gap, e.gap);
    end
    exp_q.delete();
    obs_q.delete();
    acc_q.delete();
    for (int i = 0; i < 5; i++) chk_eq($sformatf("periph_reg%0d", i), preg[i], ref_reg[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          a5;
    for (int i = 0; i < 5; i++) ref_reg[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_cs_n", cs_n, 1'b1);
    chk_eq("rst_sclk", sclk, 1'b0);
    chk_eq("rst_mosi", mosi, 1'b0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_done", done, 1'b0);
    chk_eq("rst_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("idle_req_ready", req_ready, 1'b1);

    // Write 0x80 to PWM duty.
    push_cmd({1'b1, 7'h04, 8'h80}, LAT, -1, 1);
    req_valid = 1'b0;
    wait_frames();
    compare_frames();

    // Read frame: shifted unchanged, registers untouched.
    push_cmd({1'b0, 7'h00, 8'hFF}, LAT, -1, 1);
    req_valid = 1'b0;
    wait_frames();
    compare_frames();

    // Two commands with req_valid held.
    push_cmd({1'b1, 7'h00, 8'($urandom)}, LAT, -1, 1);
    push_cmd({1'b1, 7'h02, 8'($urandom)}, LAT2, CSG + 1, 1);
    req_valid = 1'b0;
    wait_frames();
    compare_frames();

    // Reset pulse after the 8th SCLK rise.
    push_cmd({1'b1, 7'h01, ~ref_reg[1]}, -1, -1, 0);
    req_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (rises < 8 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk_eq("reached_8th_rise", rises >= 8, 1'b1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_eq("async_rst_cs_n", cs_n, 1'b1);
    chk_eq("async_rst_sclk", sclk, 1'b0);
    chk_eq("async_rst_busy", busy, 1'b0);
    chk_eq("async_rst_req_ready", req_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compare_frames();

    push_cmd({1'b1, 7'h00, 8'hFF}, LAT, -1, 1);
    req_valid = 1'b0;
    wait_frames();
    compare_frames();

`ifdef SPI_CONTROLLER_FIFO_EN
    // Six back-to-back pushes into the FIFO.
    for (int i = 0; i < 6; i++) begin
      w = {1'b1, 7'(i % 5), 8'($urandom)};
      push_cmd(w, (i == 0) ? LAT : -1, (i == 0) ? -1 : CSG + 1, 1);
    end
    req_valid = 1'b0;
    wait_frames();
    for (int i = 1; i < 5; i++) chk_eq($sformatf("fifo_accept_%0d", i), acc_q[i] - acc_q[0], i);
    a5 = acc_q[5];
    if (obs_q.size() > 1) chk_eq("fifo_6th_accept_at_2nd_pop", a5, obs_q[1].fall);
    compare_frames();
`endif

    // Randomized isolated commands.
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      w = {1'($urandom), 7'($urandom_range(0, 6)), 8'($urandom)};
      push_cmd(w, LAT, -1, 1);
      req_valid = 1'b0;
      wait_frames();
      compare_frames();
    end

    repeat (5) @(negedge clk);
    chk_eq("done_pulse_count", done_cnt, frames_sent);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
